// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, direct/load modes and
// an auto-scan mode that steps the index up or down every PERIOD enabled cycles.
module scan_decoder #(
    parameter int N      = 2,
    parameter int PERIOD = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N-1:0]      A,
    input  logic              EN,
    input  logic [1:0]        MODE,
    output logic [2**N-1:0]   Y,
    output logic [N-1:0]      IDX,
    output logic              WRAP
);

    localparam int                WIDTH     = 2**N;
    localparam int                TW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(PERIOD - 1);
    localparam logic [N-1:0]      IDX_MAX   = '1;
    localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_LOAD      = 2'b11
    } mode_t;

    mode_t          mode;
    logic [TW-1:0]  tick;
    logic [TW-1:0]  tick_next;
    logic [N-1:0]   idx_next;
    logic           wrap_next;

    assign mode = mode_t'(MODE);

    // The tick counter survives a direct UP<->DOWN switch, so a pending step
    // simply takes whichever direction is sampled on the edge it fires.
    always_comb begin
        tick_next = '0;
        idx_next  = IDX;
        wrap_next = 1'b0;
        if (EN) begin
            case (mode)
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    if (tick == TICK_LAST) begin
                        if (mode == MODE_SCAN_UP) begin
                            idx_next  = IDX + 1'b1;
                            wrap_next = (IDX == IDX_MAX);
                        end else begin
                            idx_next  = IDX - 1'b1;
                            wrap_next = (IDX == '0);
                        end
                    end else begin
                        tick_next = tick + 1'b1;
                    end
                end
                default: idx_next = A;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick <= '0;
            IDX  <= '0;
            WRAP <= 1'b0;
            Y    <= '0;
        end else begin
            tick <= tick_next;
            IDX  <= idx_next;
            WRAP <= wrap_next;
            Y    <= EN ? (ONE << idx_next) : '0;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: three parameter sets share one stimulus
// stream; a counting reference model predicts each cycle's outputs.
module tb_scan_decoder;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    localparam int N_OF[3] = '{2, 2, 3};
    localparam int P_OF[3] = '{1, 3, 2};

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic       EN    = 1'b0;
    logic [1:0] MODE  = 2'b00;
    logic [2:0] a_sel = 3'd0;

    logic [3:0] y_a;   logic [1:0] idx_a;  logic wrap_a;
    logic [3:0] y_b;   logic [1:0] idx_b;  logic wrap_b;
    logic [7:0] y_c;   logic [2:0] idx_c;  logic wrap_c;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int m_idx[3];
    int m_tick[3];
    int cycle_no     = 0;

    scan_decoder #(.N(2), .PERIOD(1)) u_n2p1 (
        .CLK(CLK), .RST_N(RST_N), .A(a_sel[1:0]), .EN(EN), .MODE(MODE),
        .Y(y_a), .IDX(idx_a), .WRAP(wrap_a));

    scan_decoder #(.N(2), .PERIOD(3)) u_n2p3 (
        .CLK(CLK), .RST_N(RST_N), .A(a_sel[1:0]), .EN(EN), .MODE(MODE),
        .Y(y_b), .IDX(idx_b), .WRAP(wrap_b));

    scan_decoder #(.N(3), .PERIOD(2)) u_n3p2 (
        .CLK(CLK), .RST_N(RST_N), .A(a_sel), .EN(EN), .MODE(MODE),
        .Y(y_c), .IDX(idx_c), .WRAP(wrap_c));

    initial forever #5 CLK = ~CLK;

    function automatic exp_t actualOf(int k);
        exp_t r;
        case (k)
            0:       r = '{y: {4'b0, y_a}, idx: {1'b0, idx_a}, wrap: wrap_a};
            1:       r = '{y: {4'b0, y_b}, idx: {1'b0, idx_b}, wrap: wrap_b};
            default: r = '{y: y_c, idx: idx_c, wrap: wrap_c};
        endcase
        return r;
    endfunction

    // Reference: count enabled scan cycles; every PERIOD-th one moves the index.
    function automatic exp_t modelStep(int k, logic en, logic [1:0] mode, int a);
        exp_t e;
        int   size;
        size   = 1 << N_OF[k];
        e      = '0;
        if (!en) begin
            m_tick[k] = 0;
        end else if (mode == 2'b00 || mode == 2'b11) begin
            m_idx[k]  = a % size;
            m_tick[k] = 0;
            e.y       = 8'd1 << m_idx[k];
        end else begin
            m_tick[k] = m_tick[k] + 1;
            if (m_tick[k] == P_OF[k]) begin
                m_tick[k] = 0;
                if (mode == 2'b01) begin
                    m_idx[k] = (m_idx[k] + 1) % size;
                    e.wrap   = (m_idx[k] == 0);
                end else begin
                    m_idx[k] = (m_idx[k] + size - 1) % size;
                    e.wrap   = (m_idx[k] == size - 1);
                end
            end
            e.y = 8'd1 << m_idx[k];
        end
        e.idx = 3'(m_idx[k]);
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t got, input exp_t want);
        tests_run = tests_run + 1;
        if (got !== want) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s cycle %0d: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b",
                     name, cycle_no, got.y, got.idx, got.wrap, want.y, want.idx, want.wrap);
        end
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge, wait one cycle.
    task automatic applyStimulus(input logic en, input logic [1:0] mode, input int a);
        EN    = en;
        MODE  = mode;
        a_sel = 3'(a);
        q0.push_back(modelStep(0, en, mode, a));
        q1.push_back(modelStep(1, en, mode, a));
        q2.push_back(modelStep(2, en, mode, a));
        @(negedge CLK);
    endtask

    task automatic asyncReset(input string name);
        #2 RST_N = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_dut%0d", name, k), actualOf(k), '0);
            m_idx[k]  = 0;
            m_tick[k] = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    always begin
        @(posedge CLK);
        #1;
        cycle_no = cycle_no + 1;
        if (RST_N) begin
            if (q0.size() > 0) checkOutput("n2p1", actualOf(0), q0.pop_front());
            if (q1.size() > 0) checkOutput("n2p3", actualOf(1), q1.pop_front());
            if (q2.size() > 0) checkOutput("n3p2", actualOf(2), q2.pop_front());
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_idx[k]  = 0;
            m_tick[k] = 0;
        end
        #2 RST_N = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("reset_dut%0d", k), actualOf(k), '0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, i);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, i);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, i);

        applyStimulus(1'b1, 2'b11, 2);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 2'b01, 0);

        applyStimulus(1'b1, 2'b11, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b10, 3);

        applyStimulus(1'b1, 2'b11, 5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 2'b01, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b10, 0);

        applyStimulus(1'b1, 2'b11, 2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 0);
        asyncReset("midscan_reset");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b01, 3);

        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)));

        @(negedge CLK);
        tests_run = tests_run + 1;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL drain: got %0d pending, want 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with enable, extending the team's 2-to-4 enable decoder with sequential modes. Besides direct decode, it can preset an index and then auto-scan it up or down at a programmable rate, with a wrap pulse at each rollover. It drives one-hot select lines such as display digit strobes, bank selects or round-robin channel enables.

## Interface
- N, default 2: select width; output width is 2^N (N ≥ 1).
- PERIOD, default 1: enabled clock cycles per scan step (PERIOD ≥ 1).
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- A  input  N  select/preset index.
- EN  input  1  enable; 0 forces all outputs inactive.
- MODE  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 LOAD.
- Y  output  2^N  registered one-hot output; Y[i]=1 selects index i.
- IDX  output  N  registered current index.
- WRAP  output  1  one-cycle pulse on scan rollover.

## Operation
- State: IDX register (N bits), tick counter (max(1,clog2(PERIOD)) bits), Y register, WRAP register.
- EN=0, any MODE: Y←0, WRAP←0, tick←0, IDX holds.
- EN=1, DIRECT: IDX←A, Y←onehot(A), tick←0, WRAP←0.
- EN=1, LOAD: identical register update to DIRECT. Use it to preset a scan start point, then switch MODE to a scan mode.
- EN=1, SCAN_UP:
  - tick<PERIOD-1: tick←tick+1, Y←onehot(IDX), WRAP←0.
  - tick=PERIOD-1: tick←0, IDX←IDX+1 mod 2^N, Y←onehot(new IDX).
  - WRAP←1 only when IDX goes from 2^N-1 to 0.
- EN=1, SCAN_DOWN: same as SCAN_UP, but IDX←IDX-1 mod 2^N. WRAP←1 only when IDX goes from 0 to 2^N-1.
- Tick counter clearing:
  - Cleared by EN=0, DIRECT or LOAD.
  - Not cleared by switching directly between SCAN_UP and SCAN_DOWN. The pending step then takes the new direction.
- PERIOD=1: steps every enabled cycle, and the tick counter stays 0.
- A is ignored in scan modes.
- Invariant: Y is all-zero or exactly one-hot, never multi-hot. When Y≠0, Y=onehot(IDX).

## Timing
- Reset (RST_N=0): Y=0, IDX=0, WRAP=0, tick=0, applied immediately and asynchronously.
- After RST_N deasserts, the first update happens on the next rising CLK edge.
- All outputs are registered, with no combinational path from any input to any output.
- DIRECT/LOAD latency: Y and IDX reflect A one cycle after the sampling edge.
- EN falling: Y=0 after the next edge.
- EN rising in a scan mode: Y=onehot(held IDX) after the first edge. The first step occurs on the PERIOD-th enabled edge.
- Scan step cadence: IDX changes exactly once every PERIOD edges while EN=1 and MODE stays in a scan mode.
- WRAP is high for exactly one cycle, aligned with the cycle in which IDX shows the wrapped value.
- Reset asserted mid-scan: all state clears at once, and no WRAP is emitted. After release, the scan restarts from IDX=0 with a full PERIOD wait.
- MODE and A change only at clock edges; the value sampled at an edge determines the update made on that edge.

## Test plan
- Reset, then DIRECT with N=2 and EN=1 stepping A=0,1,2,3 → Y=0001,0010,0100,1000 one cycle later each; IDX tracks A; WRAP=0 throughout.
- EN=0 for all four A values, in both DIRECT and SCAN_UP → Y=0000; IDX holds its last value; WRAP=0.
- N=2, PERIOD=3: LOAD with A=2, then SCAN_UP for 12 cycles → IDX runs 2,3,0,1, each value held 3 cycles. WRAP is 1 only in the first cycle where IDX=0. Y matches onehot(IDX) in every cycle.
- N=2, PERIOD=1, SCAN_DOWN from IDX=1 → IDX runs 0,3,2,1,0, changing every cycle. WRAP=1 exactly in the cycles where IDX becomes 3.
- N=3, PERIOD=2, mid-scan: drop EN for 2 cycles, then restore it → Y=0 while EN=0. After EN returns, IDX resumes from its held value and the first step comes 2 edges later. Switching from SCAN_UP to SCAN_DOWN between steps reverses the direction on the pending step.
- Assert RST_N low asynchronously mid-scan, between clock edges, with PERIOD=3 → Y, IDX and WRAP read 0 before the next edge. After release in SCAN_UP, IDX=1 appears on the 3rd edge.
